// File: rtl/morse_button_conditioner.sv
// N-channel button front-end: sync, debounce, press/release, short/long, autorepeat.
// Optional MORSE_REPEAT_ACCEL_EN: repeat interval halves every 4 repeats.
module morse_button_conditioner #(
    parameter int NUM_BTN                = 5,
    parameter int SYNC_STAGES            = 2,
    parameter int DEBOUNCE_CYCLES        = 50000,
    parameter int LONG_PRESS_CYCLES      = 2500000,
    parameter int REPEAT_DELAY_CYCLES    = 5000000,
    parameter int REPEAT_INTERVAL_CYCLES = 1000000,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] release_pulse,
    output logic [NUM_BTN-1:0] short_pulse,
    output logic [NUM_BTN-1:0] long_pulse,
    output logic [NUM_BTN-1:0] repeat_pulse,
    output logic [NUM_BTN-1:0] long_held,
    output logic               any_pressed
);
    localparam int HOLD_MAX = (LONG_PRESS_CYCLES > REPEAT_DELAY_CYCLES)
                            ? LONG_PRESS_CYCLES : REPEAT_DELAY_CYCLES;
    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int IW = $clog2(REPEAT_INTERVAL_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_TOP   = HW'(HOLD_MAX);
    localparam logic [HW-1:0] LONG_LAST  = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HW-1:0] DELAY_LAST = HW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [IW-1:0] INT_FULL   = IW'(REPEAT_INTERVAL_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_LONG} state_t;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        localparam bit REP_EN = REPEAT_MASK[g];

        logic [SYNC_STAGES-1:0] r_sync;
        logic [DW-1:0]          r_db;
        logic                   r_level;
        state_t                 r_state;
        logic [HW-1:0]          r_hold;
        logic [IW-1:0]          r_ic;
        logic                   r_rep_on;
        logic                   r_press, r_rel, r_short, r_long, r_rep, r_held;
        logic                   w_sync, w_diff, w_tog, w_act, w_fire;
        logic [IW-1:0]          w_int_last;

        assign w_sync = r_sync[SYNC_STAGES-1];
        assign w_diff = (w_sync != r_level);
        assign w_tog  = w_diff && (r_db == DB_LAST);
        // w_tog while not IDLE is the debounced fall; it suppresses any repeat
        assign w_act  = REP_EN && (r_state != S_IDLE) && !w_tog;
        assign w_fire = w_act && (r_rep_on ? (r_ic == w_int_last)
                                           : (r_hold == DELAY_LAST));

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync  <= '0;
                r_db    <= '0;
                r_level <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in[g]};
                if (!w_diff || w_tog) r_db <= '0;
                else                  r_db <= r_db + 1'b1;
                if (w_tog) r_level <= !r_level;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state  <= S_IDLE;
                r_hold   <= '0;
                r_ic     <= '0;
                r_rep_on <= 1'b0;
                r_press  <= 1'b0;
                r_rel    <= 1'b0;
                r_short  <= 1'b0;
                r_long   <= 1'b0;
                r_rep    <= 1'b0;
                r_held   <= 1'b0;
            end else begin
                r_press <= 1'b0;
                r_rel   <= 1'b0;
                r_short <= 1'b0;
                r_long  <= 1'b0;
                r_rep   <= 1'b0;
                unique case (r_state)
                    S_IDLE: begin
                        if (w_tog) begin
                            r_state <= S_PRESSED;
                            r_press <= 1'b1;
                            r_hold  <= '0;
                        end
                    end
                    S_PRESSED, S_LONG: begin
                        if (w_tog) begin
                            r_state  <= S_IDLE;
                            r_rel    <= 1'b1;
                            r_short  <= (r_state == S_PRESSED);
                            r_held   <= 1'b0;
                            r_rep_on <= 1'b0;
                            r_ic     <= '0;
                        end else begin
                            if (r_hold != HOLD_TOP) r_hold <= r_hold + 1'b1;
                            if (r_state == S_PRESSED && r_hold == LONG_LAST) begin
                                r_state <= S_LONG;
                                r_long  <= 1'b1;
                                r_held  <= 1'b1;
                            end
                            if (w_fire) begin
                                r_rep    <= 1'b1;
                                r_rep_on <= 1'b1;
                                r_ic     <= '0;
                            end else if (r_rep_on) begin
                                r_ic <= r_ic + 1'b1;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end

`ifdef MORSE_REPEAT_ACCEL_EN
        localparam logic [IW-1:0] INT_MIN = IW'(REPEAT_INTERVAL_CYCLES / 4);
        logic [IW-1:0] r_int;
        logic [1:0]    r_acc;
        logic [IW-1:0] w_half;

        assign w_half     = r_int >> 1;
        assign w_int_last = r_int - 1'b1;

        always_ff @(posedge clk) begin
            if (rst || r_state == S_IDLE) begin
                r_int <= INT_FULL;
                r_acc <= '0;
            end else if (w_fire) begin
                r_acc <= r_acc + 1'b1;
                if (r_acc == 2'd3) r_int <= (w_half < INT_MIN) ? INT_MIN : w_half;
            end
        end
`else
        assign w_int_last = INT_FULL - 1'b1;
`endif

        assign btn_level[g]     = r_level;
        assign press_pulse[g]   = r_press;
        assign release_pulse[g] = r_rel;
        assign short_pulse[g]   = r_short;
        assign long_pulse[g]    = r_long;
        assign repeat_pulse[g]  = r_rep;
        assign long_held[g]     = r_held;
    end

    assign any_pressed = |btn_level;

endmodule

// File: tb/tb_morse_button_conditioner.sv
// Scoreboard bench for morse_button_conditioner; expected events are queued
// with their cycle and compared against every output each cycle.
module tb_morse_button_conditioner;
    localparam int NB = 5;
    localparam int K_PR = 0, K_RL = 1, K_SH = 2, K_LG = 3, K_RP = 4;

    typedef struct {
        int cyc;
        int kind;
        int ch;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_in;
    logic [NB-1:0] btn_level, press_pulse, release_pulse, short_pulse;
    logic [NB-1:0] long_pulse, repeat_pulse, long_held;
    logic          any_pressed;

    int   cyc = 0;
    logic rst_q = 1'b1;
    logic mon_en = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    ev_t  sb[$];

    logic [NB-1:0] e_pr, e_rl, e_sh, e_lg, e_rp;
    logic [NB-1:0] e_lv = '0;
    logic [NB-1:0] e_hd = '0;

    morse_button_conditioner #(
        .NUM_BTN(5),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4),
        .LONG_PRESS_CYCLES(20),
        .REPEAT_DELAY_CYCLES(30),
        .REPEAT_INTERVAL_CYCLES(8),
        .REPEAT_MASK(5'b00100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .btn_level(btn_level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .short_pulse(short_pulse),
        .long_pulse(long_pulse),
        .repeat_pulse(repeat_pulse),
        .long_held(long_held),
        .any_pressed(any_pressed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    function automatic void push(int c, int k, int ch);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.ch   = ch;
        sb.push_back(e);
    endfunction

    task automatic until_cyc(int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Pop this cycle's expected events and compare every output
    always @(negedge clk) begin : mon
        int i;
        if (mon_en) begin
            e_pr = '0; e_rl = '0; e_sh = '0; e_lg = '0; e_rp = '0;
            i = 0;
            while (i < sb.size()) begin
                if (sb[i].cyc == cyc) begin
                    case (sb[i].kind)
                        K_PR:    e_pr[sb[i].ch] = 1'b1;
                        K_RL:    e_rl[sb[i].ch] = 1'b1;
                        K_SH:    e_sh[sb[i].ch] = 1'b1;
                        K_LG:    e_lg[sb[i].ch] = 1'b1;
                        default: e_rp[sb[i].ch] = 1'b1;
                    endcase
                    sb.delete(i);
                end else begin
                    i++;
                end
            end
            if (rst_q) begin
                e_lv = '0;
                e_hd = '0;
            end else begin
                e_lv = (e_lv | e_pr) & ~e_rl;
                e_hd = (e_hd | e_lg) & ~e_rl;
            end
            chk("press",   8'(press_pulse),   8'(e_pr));
            chk("release", 8'(release_pulse), 8'(e_rl));
            chk("short",   8'(short_pulse),   8'(e_sh));
            chk("long",    8'(long_pulse),    8'(e_lg));
            chk("repeat",  8'(repeat_pulse),  8'(e_rp));
            chk("level",   8'(btn_level),     8'(e_lv));
            chk("held",    8'(long_held),     8'(e_hd));
            chk("any",     8'(any_pressed),   8'(|e_lv));
        end
    end

    initial begin : stim
        int p, r, t;
        int rel_off;
        int gaps[$];
`ifdef MORSE_REPEAT_ACCEL_EN
        gaps    = '{8, 8, 8, 4, 4, 4, 4, 2, 2};
        rel_off = 76;
`else
        gaps    = '{8, 8, 8, 8};
        rel_off = 70;
`endif
        rst    = 1'b1;
        btn_in = '0;
        @(negedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_level", 8'(btn_level), 8'd0);
        chk("rst_press", 8'(press_pulse), 8'd0);
        chk("rst_held",  8'(long_held), 8'd0);
        chk("rst_any",   8'(any_pressed), 8'd0);
        rst = 1'b0;
        until_cyc(cyc + 3);

        // Press on ch0, 3-cycle glitch on ch1, short release on ch0
        p = cyc + 6;
        btn_in[0] = 1'b1;
        btn_in[1] = 1'b1;
        push(p, K_PR, 0);
        until_cyc(cyc + 3);
        btn_in[1] = 1'b0;
        until_cyc(p + 10);
        btn_in[0] = 1'b0;
        push(cyc + 6, K_RL, 0);
        push(cyc + 6, K_SH, 0);
        until_cyc(cyc + 12);

        // Long press on ch3
        p = cyc + 6;
        btn_in[3] = 1'b1;
        push(p, K_PR, 3);
        push(p + 20, K_LG, 3);
        until_cyc(p + 25);
        btn_in[3] = 1'b0;
        push(cyc + 6, K_RL, 3);
        until_cyc(cyc + 10);

        // Autorepeat on ch2, same hold on unmasked ch4
        p = cyc + 6;
        btn_in[2] = 1'b1;
        btn_in[4] = 1'b1;
        push(p, K_PR, 2);
        push(p, K_PR, 4);
        push(p + 20, K_LG, 2);
        push(p + 20, K_LG, 4);
        t = p + 30;
        push(t, K_RP, 2);
        foreach (gaps[k]) begin
            t += gaps[k];
            push(t, K_RP, 2);
        end
        until_cyc(p + rel_off - 6);
        btn_in[2] = 1'b0;
        btn_in[4] = 1'b0;
        push(p + rel_off, K_RL, 2);
        push(p + rel_off, K_RL, 4);
        until_cyc(cyc + 10);

        // Reset while ch3 is in LONG, button still held afterwards
        p = cyc + 6;
        btn_in[3] = 1'b1;
        push(p, K_PR, 3);
        push(p + 20, K_LG, 3);
        until_cyc(p + 22);
        rst = 1'b1;
        @(negedge clk);
        chk("inrst_level", 8'(btn_level), 8'd0);
        chk("inrst_held",  8'(long_held), 8'd0);
        chk("inrst_any",   8'(any_pressed), 8'd0);
        until_cyc(p + 25);
        rst = 1'b0;
        r = cyc;
        push(r + 6, K_PR, 3);
        push(r + 26, K_LG, 3);
        until_cyc(r + 30);
        btn_in[3] = 1'b0;
        push(cyc + 6, K_RL, 3);
        until_cyc(cyc + 10);

        chk("leftover", 8'(sb.size()), 8'd0);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
